// File: rtl/delay_probe_rx_if.sv
// Handshake and result bundle between the delay probe receiver and its surroundings.
// DELAY_PROBE_WIDTH_EN adds the echo_width result field.
interface delay_probe_rx_if #(
    parameter int CNT_W = 12
);
    logic             start;
    logic             echo_in;
    logic             launch;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             flush_err;
    logic             match;
    logic [CNT_W-1:0] latency;
`ifdef DELAY_PROBE_WIDTH_EN
    logic [CNT_W-1:0] echo_width;

    modport master (
        output start, echo_in,
        input  launch, busy, done, timeout, flush_err, match, latency, echo_width
    );
    modport slave (
        input  start, echo_in,
        output launch, busy, done, timeout, flush_err, match, latency, echo_width
    );
`else
    modport master (
        output start, echo_in,
        input  launch, busy, done, timeout, flush_err, match, latency
    );
    modport slave (
        input  start, echo_in,
        output launch, busy, done, timeout, flush_err, match, latency
    );
`endif
endinterface

// File: rtl/delay_probe_rx.sv
// Measures the round-trip latency of a single-bit delay chain: flush, launch a pulse, time the echo.
// Optional feature macro DELAY_PROBE_WIDTH_EN: also measures the width of the returning pulse.
module delay_probe_rx #(
    parameter int CNT_W      = 12,
    parameter int TIMEOUT    = 4095,
    parameter int QUIET      = 16,
    parameter int EXPECT_LAT = 360
) (
    input  logic           clk,
    input  logic           rst,
    delay_probe_rx_if.slave bus
);
    localparam logic [CNT_W-1:0] L_TIMEOUT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] L_QUIET_M1 = CNT_W'(QUIET - 1);
    localparam logic [CNT_W-1:0] L_EXPECT   = CNT_W'(EXPECT_LAT);
    localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

`ifdef DELAY_PROBE_WIDTH_EN
    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_LAUNCH, S_WAIT, S_WIDTH, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_LAUNCH, S_WAIT, S_DONE} state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_quiet_cnt;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic             r_launch;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic             r_flush_err;
    logic             r_match;
    logic [CNT_W-1:0] r_latency;
`ifdef DELAY_PROBE_WIDTH_EN
    logic [CNT_W-1:0] r_arr_lat;
    logic [CNT_W-1:0] r_echo_width;
    assign bus.echo_width = r_echo_width;
`endif

    assign bus.launch    = r_launch;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.timeout   = r_timeout;
    assign bus.flush_err = r_flush_err;
    assign bus.match     = r_match;
    assign bus.latency   = r_latency;

    function automatic logic f_match(input logic [CNT_W-1:0] lat, input logic to);
        return (lat == L_EXPECT) && !to;
    endfunction

    // Measurement sequencer: all outputs are registered and change on the state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_quiet_cnt  <= '0;
            r_cyc_cnt    <= '0;
            r_launch     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_flush_err  <= 1'b0;
            r_match      <= 1'b0;
            r_latency    <= '0;
`ifdef DELAY_PROBE_WIDTH_EN
            r_arr_lat    <= '0;
            r_echo_width <= '0;
`endif
        end else begin
            r_launch <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_quiet_cnt <= '0;
                    r_cyc_cnt   <= '0;
                    if (bus.start) begin
                        r_state     <= S_FLUSH;
                        r_busy      <= 1'b1;
                        r_timeout   <= 1'b0;
                        r_flush_err <= 1'b0;
                        r_match     <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (!bus.echo_in && (r_quiet_cnt == L_QUIET_M1)) begin
                        r_state   <= S_LAUNCH;
                        r_launch  <= 1'b1;
                        r_cyc_cnt <= '0;
                    end else if (r_cyc_cnt == L_TIMEOUT) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_timeout   <= 1'b1;
                        r_flush_err <= 1'b1;
                        r_latency   <= L_TIMEOUT;
                        r_match     <= 1'b0;
`ifdef DELAY_PROBE_WIDTH_EN
                        r_echo_width <= '0;
`endif
                    end else begin
                        r_cyc_cnt   <= r_cyc_cnt + L_ONE;
                        r_quiet_cnt <= bus.echo_in ? '0 : (r_quiet_cnt + L_ONE);
                    end
                end
                // cyc_cnt is 0 during LAUNCH, so it is the latency in both states.
                S_LAUNCH, S_WAIT: begin
                    if (bus.echo_in) begin
`ifdef DELAY_PROBE_WIDTH_EN
                        r_state   <= S_WIDTH;
                        r_arr_lat <= r_cyc_cnt;
                        r_cyc_cnt <= L_ONE;
`else
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_latency <= r_cyc_cnt;
                        r_match   <= f_match(r_cyc_cnt, 1'b0);
`endif
                    end else if ((r_state == S_WAIT) && (r_cyc_cnt == L_TIMEOUT)) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_latency <= L_TIMEOUT;
                        r_match   <= 1'b0;
`ifdef DELAY_PROBE_WIDTH_EN
                        r_echo_width <= '0;
`endif
                    end else begin
                        r_state   <= S_WAIT;
                        r_cyc_cnt <= r_cyc_cnt + L_ONE;
                    end
                end
`ifdef DELAY_PROBE_WIDTH_EN
                S_WIDTH: begin
                    if (!bus.echo_in || (r_cyc_cnt == L_TIMEOUT)) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_latency    <= r_arr_lat;
                        r_match      <= f_match(r_arr_lat, 1'b0);
                        r_echo_width <= r_cyc_cnt;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + L_ONE;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_delay_probe_rx.sv
// Bench for delay_probe_rx: behavioural chain environment plus an event-list reference model.
module tb_delay_probe_rx;
    localparam int CNT_W      = 12;
    localparam int TIMEOUT    = 4095;
    localparam int QUIET      = 16;
    localparam int EXPECT_LAT = 360;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    delay_probe_rx_if #(.CNT_W(CNT_W)) bus();

    delay_probe_rx #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .QUIET(QUIET), .EXPECT_LAT(EXPECT_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;   // 0: chain of n registers (n=0 is a wire), 1: tied low, 2: tied high
    int n      = 0;
    logic inj = 1'b0, stretch = 1'b0, clr = 1'b0;
    logic l1 = 1'b0, l2 = 1'b0;
    logic [511:0] chain = '0;
    logic chain_in;
    int hot[$];       // cycles in which a 1 entered the chain input

    assign chain_in    = bus.launch | inj | (stretch & (l1 | l2));
    assign bus.echo_in = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 :
                         (n == 0) ? chain_in : chain[(n == 0) ? 0 : n - 1];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        l1    <= bus.launch;
        l2    <= l1;
        chain <= clr ? '0 : {chain[510:0], chain_in};
    end

    typedef struct {
        string nm; int mode; int n; bit strch; int lat; int mt; int to; int fe;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input int md, input int nn, input bit st,
                                input int lat, input int mt, input int to, input int fe);
        vec_t v;
        v.nm = nm; v.mode = md; v.n = nn; v.strch = st;
        v.lat = lat; v.mt = mt; v.to = to; v.fe = fe;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected chain output in cycle c: a 1 that entered n cycles earlier.
    function automatic bit echo_at(input int c);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        foreach (hot[i]) if (hot[i] + n == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".launch"}, int'(bus.launch), 0);
        chk({tag, ".busy"}, int'(bus.busy), 0);
        chk({tag, ".done"}, int'(bus.done), 0);
        chk({tag, ".timeout"}, int'(bus.timeout), 0);
        chk({tag, ".flush_err"}, int'(bus.flush_err), 0);
        chk({tag, ".match"}, int'(bus.match), 0);
        chk({tag, ".latency"}, int'(bus.latency), 0);
`ifdef DELAY_PROBE_WIDTH_EN
        chk({tag, ".echo_width"}, int'(bus.echo_width), 0);
`endif
    endtask

    task automatic clear_chain();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        hot.delete();
    endtask

    // Issue start now, predict the whole measurement, then observe the DUT until done.
    task automatic run_case(input string nm, output int a_lat, output int a_mt,
                            output int a_to, output int a_fe);
        int s, f, dec, lp, lat, w, dn, to, fe, seen_l, n_l, seen_d, lim;
        s = cyc;
        f = s + 1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dec = -1;
        for (int c = f + QUIET - 1; c <= f + TIMEOUT; c++) begin
            bit q = 1'b1;
            for (int k = 0; k < QUIET; k++) if (echo_at(c - k)) q = 1'b0;
            if (q) begin dec = c; break; end
        end
        w = 0;
        if (dec < 0) begin
            lp = -1; to = 1; fe = 1; lat = TIMEOUT; dn = f + TIMEOUT + 1;
        end else begin
            lp = dec + 1;
            fe = 0;
            hot.push_back(lp);
            if (stretch) begin hot.push_back(lp + 1); hot.push_back(lp + 2); end
            lat = -1;
            for (int k = 0; k <= TIMEOUT; k++) if (echo_at(lp + k)) begin lat = k; break; end
            if (lat < 0) begin
                to = 1; lat = TIMEOUT; dn = lp + TIMEOUT + 1;
            end else begin
                to = 0;
                while (echo_at(lp + lat + w) && w < TIMEOUT) w++;
                dn = lp + lat + 1;
`ifdef DELAY_PROBE_WIDTH_EN
                dn = dn + w;
`endif
            end
        end
        lim = dn + 20; seen_l = -1; n_l = 0; seen_d = -1;
        while (seen_d < 0 && cyc <= lim) begin
            if (bus.launch) begin
                n_l++;
                if (seen_l < 0) seen_l = cyc;
            end
            if (bus.done) seen_d = cyc;
            else @(negedge clk);
        end
        chk({nm, ".done_cycle"}, seen_d, dn);
        chk({nm, ".launch_count"}, n_l, (lp < 0) ? 0 : 1);
        if (lp >= 0) chk({nm, ".launch_cycle"}, seen_l, lp);
        chk({nm, ".latency"}, int'(bus.latency), lat);
        chk({nm, ".timeout"}, int'(bus.timeout), to);
        chk({nm, ".flush_err"}, int'(bus.flush_err), fe);
        chk({nm, ".match"}, int'(bus.match), (lat == EXPECT_LAT && to == 0) ? 1 : 0);
`ifdef DELAY_PROBE_WIDTH_EN
        chk({nm, ".echo_width"}, int'(bus.echo_width), w);
`endif
        a_lat = int'(bus.latency); a_mt = int'(bus.match);
        a_to = int'(bus.timeout);  a_fe = int'(bus.flush_err);
        @(negedge clk);
        chk({nm, ".busy_after"}, int'(bus.busy), 0);
        chk({nm, ".done_after"}, int'(bus.done), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_lat, a_mt, a_to, a_fe, s, lp, nl, nd, firstl, bad_busy;
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");

        tbl.push_back(mk("chain360", 0, 360, 1'b0, 360, 1, 0, 0));
        tbl.push_back(mk("tie0", 1, 0, 1'b0, TIMEOUT, 0, 1, 0));
        tbl.push_back(mk("tie1", 2, 0, 1'b0, TIMEOUT, 0, 1, 1));
        tbl.push_back(mk("loopback", 0, 0, 1'b0, 0, 0, 0, 0));
        tbl.push_back(mk("chain5", 0, 5, 1'b0, 5, 0, 0, 0));
`ifdef DELAY_PROBE_WIDTH_EN
        tbl.push_back(mk("stretch360", 0, 360, 1'b1, 360, 1, 0, 0));
`endif
        foreach (tbl[i]) begin
            mode = tbl[i].mode; n = tbl[i].n; stretch = tbl[i].strch;
            clear_chain();
            run_case(tbl[i].nm, a_lat, a_mt, a_to, a_fe);
            chk({tbl[i].nm, ".tbl_latency"}, a_lat, tbl[i].lat);
            chk({tbl[i].nm, ".tbl_match"}, a_mt, tbl[i].mt);
            chk({tbl[i].nm, ".tbl_timeout"}, a_to, tbl[i].to);
            chk({tbl[i].nm, ".tbl_flush_err"}, a_fe, tbl[i].fe);
        end
        stretch = 1'b0;

        // Repeated starts while busy, then reset late in WAIT with the pulse still in flight.
        mode = 0; n = 360;
        clear_chain();
        s = cyc; lp = s + 1 + QUIET; nl = 0; nd = 0; firstl = -1; bad_busy = 0;
        bus.start = 1'b1;
        @(negedge clk);
        while (cyc < lp + 350) begin
            bus.start = (cyc < s + 60) ? ~bus.start : 1'b0;
            if (bus.launch) begin
                nl++;
                if (firstl < 0) firstl = cyc;
            end
            if (bus.done) nd++;
            if (!bus.busy) bad_busy++;
            @(negedge clk);
        end
        chk("busy_starts.launch_count", nl, 1);
        chk("busy_starts.launch_cycle", firstl, lp);
        chk("busy_starts.done_count", nd, 0);
        chk("busy_starts.busy_drops", bad_busy, 0);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("mid_wait_rst");
        hot.push_back(lp);
        run_case("stale", a_lat, a_mt, a_to, a_fe);
        chk("stale.tbl_latency", a_lat, EXPECT_LAT);
        chk("stale.tbl_match", a_mt, 1);

        // Random chain lengths with random junk already travelling in the chain.
        for (int it = 0; it < 10; it++) begin
            int g;
            n = $urandom_range(400, 1);
            clear_chain();
            g = $urandom_range(30, 0);
            for (int k = 0; k < g; k++) begin
                inj = ($urandom_range(3, 0) == 0);
                if (inj) hot.push_back(cyc);
                @(negedge clk);
            end
            inj = 1'b0;
            run_case($sformatf("rand%0d_n%0d", it, n), a_lat, a_mt, a_to, a_fe);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
